// File: rtl/pong_timebase_pkg.sv
// pong_pkg: shared widths, default timing constants and timeout FSM encoding for pong_timebase
package pong_pkg;
  typedef enum logic [1:0] {T_IDLE, T_RUN, T_DONE} t5_state_e;
  localparam int LVL_W = 3;
  localparam int HIT_W = 8;
  localparam int CNT_W_D = 27;
  localparam int TICK_BASE_D = 50_000_000;
  localparam int TICK_DEC_D = 5_000_000;
  localparam int TICK_MIN_D = 10_000_000;
  localparam int HITS_PER_LVL_D = 4;
  localparam int LVL_MAX_D = 7;
  localparam int T5_TICKS_D = 500_000_000;
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    return (v == 8'h99) ? v : (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
  endfunction
endpackage

// File: rtl/pong_timebase_if.sv
// pong_timebase_if: controller strobes into the timebase and its status back to the controller
interface pong_timebase_if;
  import pong_pkg::*;
  logic T20_en, T20_rst, T5_en, T5_rst, Hit_ld, Hit_clr, Lvl_clr;
  logic step_tick, T5_done, lvl_up;
  logic [HIT_W-1:0] hit_count;
  logic [LVL_W-1:0] level;
  modport master (
    output T20_en, T20_rst, T5_en, T5_rst, Hit_ld, Hit_clr, Lvl_clr,
    input  step_tick, T5_done, lvl_up, hit_count, level
  );
  modport slave (
    input  T20_en, T20_rst, T5_en, T5_rst, Hit_ld, Hit_clr, Lvl_clr,
    output step_tick, T5_done, lvl_up, hit_count, level
  );
endinterface

// File: rtl/pong_interval_timer.sv
// pong_interval_timer: enabled counter with runtime period and a one-cycle terminal pulse
module pong_interval_timer #(
  parameter int W = 27
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         i_en,
  input  logic         i_clr,
  input  logic [W-1:0] i_period,
  output logic         o_tick
);
  logic [W-1:0] r_cnt;
  logic r_tick, w_term;
  // >= so a period that shrinks below the current count fires at once instead of wrapping
  assign w_term = i_en && (r_cnt >= i_period - W'(1));
  assign o_tick = r_tick;
  always_ff @(posedge Clk or posedge Rst)
    if (Rst) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_cnt  <= (i_clr || w_term) ? '0 : i_en ? r_cnt + W'(1) : r_cnt;
      r_tick <= !i_clr && w_term;
    end
endmodule

// File: rtl/pong_timebase.sv
// pong_timebase: ball-step tick, hit/level tracking and game-over timeout for the pong controller
// Define PONG_HIT_BCD_EN to present hit_count as two packed BCD digits saturating at 0x99.
module pong_timebase
  import pong_pkg::*;
#(
  parameter int CNT_W        = CNT_W_D,
  parameter int TICK_BASE    = TICK_BASE_D,
  parameter int TICK_DEC     = TICK_DEC_D,
  parameter int TICK_MIN     = TICK_MIN_D,
  parameter int HITS_PER_LVL = HITS_PER_LVL_D,
  parameter int LVL_MAX      = LVL_MAX_D,
  parameter int T5_TICKS     = T5_TICKS_D
) (
  input logic            Clk,
  input logic            Rst,
  pong_timebase_if.slave bus
);
  localparam int PW = CNT_W + 3;
  localparam int SUB_W = $clog2(HITS_PER_LVL + 1);
  localparam int T5_W = $clog2(T5_TICKS + 1);

  logic r_hit_prev, r_lvl_up;
  logic [HIT_W-1:0] r_hit_count, w_hit_inc;
  logic [LVL_W-1:0] r_level;
  logic [SUB_W-1:0] r_sub;
  logic w_hit_edge, w_hit_acc, w_sub_full, w_lvl_inc;
  logic signed [PW-1:0] w_period_s;
  logic [CNT_W-1:0] w_period;
  t5_state_e r_t5_state, w_t5_next;
  logic [T5_W-1:0] r_t5_cnt;
  logic w_t5_term;

  // Wide signed arithmetic so high levels go negative and clamp rather than wrap
  assign w_period_s = $signed(PW'(TICK_BASE)) - $signed(PW'(r_level)) * $signed(PW'(TICK_DEC));
  assign w_period = (w_period_s < $signed(PW'(TICK_MIN))) ? CNT_W'(TICK_MIN) : w_period_s[CNT_W-1:0];

  pong_interval_timer #(.W(CNT_W)) u_step (
    .Clk      (Clk),
    .Rst      (Rst),
    .i_en     (bus.T20_en),
    .i_clr    (bus.T20_rst),
    .i_period (w_period),
    .o_tick   (bus.step_tick)
  );

  assign w_hit_edge = bus.Hit_ld && !r_hit_prev;
  assign w_hit_acc = w_hit_edge && !bus.Hit_clr;
  assign w_sub_full = (r_sub == SUB_W'(HITS_PER_LVL - 1));
  assign w_lvl_inc = w_hit_acc && w_sub_full && (r_level < LVL_W'(LVL_MAX));
`ifdef PONG_HIT_BCD_EN
  assign w_hit_inc = bcd_inc(r_hit_count);
`else
  assign w_hit_inc = (r_hit_count == '1) ? r_hit_count : r_hit_count + HIT_W'(1);
`endif

  // Binary sub-counter paces levels independently of the displayed hit format
  always_ff @(posedge Clk or posedge Rst)
    if (Rst) begin
      r_hit_prev  <= 1'b0;
      r_hit_count <= '0;
      r_sub       <= '0;
      r_level     <= '0;
      r_lvl_up    <= 1'b0;
    end else begin
      r_hit_prev  <= bus.Hit_ld;
      r_hit_count <= bus.Hit_clr ? '0 : w_hit_edge ? w_hit_inc : r_hit_count;
      r_sub       <= (bus.Lvl_clr || (w_hit_acc && w_sub_full)) ? '0 : w_hit_acc ? r_sub + SUB_W'(1) : r_sub;
      r_level     <= bus.Lvl_clr ? '0 : r_level + LVL_W'(w_lvl_inc);
      r_lvl_up    <= !bus.Lvl_clr && w_lvl_inc;
    end

  assign bus.hit_count = r_hit_count;
  assign bus.level = r_level;
  assign bus.lvl_up = r_lvl_up;

  assign w_t5_term = bus.T5_en && (r_t5_state != T_DONE) && (r_t5_cnt == T5_W'(T5_TICKS - 1));

  always_ff @(posedge Clk or posedge Rst)
    if (Rst) begin
      r_t5_state <= T_IDLE;
      r_t5_cnt   <= '0;
    end else begin
      r_t5_state <= w_t5_next;
      r_t5_cnt   <= (bus.T5_rst || w_t5_term) ? '0 : (bus.T5_en && r_t5_state != T_DONE) ? r_t5_cnt + T5_W'(1) : r_t5_cnt;
    end

  always_comb
    w_t5_next = bus.T5_rst ? T_IDLE : (r_t5_state == T_DONE || w_t5_term) ? T_DONE : bus.T5_en ? T_RUN : r_t5_state;

  always_comb
    bus.T5_done = (r_t5_state == T_DONE);
endmodule

// File: doc/pong_timebase.md
Name: pong_timebase

Overview:
Datapath and timer responder to the pong game controller's control strobes (T5_en/T5_rst, T20_en/T20_rst, Hit_ld/Hit_clr, Lvl_clr).
- Generates the ball-step tick that paces the controller. The tick period shortens as the level rises.
- Counts paddle hits and derives the level from them.
- Produces the game-over timeout T5_done, which feeds back to the controller's T5_in.
- Runs on the fast board clock; all outputs are registered.

Parameters:
CNT_W, 27, width of the internal interval counters
TICK_BASE, 50_000_000, step period in Clk cycles at level 0
TICK_DEC, 5_000_000, period reduction per level
TICK_MIN, 10_000_000, floor on the step period
HITS_PER_LVL, 4, hits needed to advance one level
LVL_MAX, 7, saturation value of the level
T5_TICKS, 500_000_000, game-over timeout length in Clk cycles

Ports:
Clk  in  1  system clock
Rst  in  1  asynchronous reset, active-high
T20_en  in  1  run the step timer
T20_rst  in  1  clear the step timer (overrides T20_en)
T5_en  in  1  run the timeout timer
T5_rst  in  1  clear the timeout timer (overrides T5_en)
Hit_ld  in  1  hit indication, level held for one or more cycles
Hit_clr  in  1  clear the hit counter
Lvl_clr  in  1  clear the level
step_tick  out  1  one-cycle pulse per ball step
T5_done  out  1  timeout expired, sticky
hit_count  out  8  hits this game
level  out  3  current level
lvl_up  out  1  one-cycle pulse when the level increments

Behaviour:
Reset (Rst high, async):
- All counters cleared, level=0, hit_count=0.
- step_tick=0, T5_done=0, lvl_up=0.
- Timeout FSM in T_IDLE.

Step period:
- period = max(TICK_BASE - level*TICK_DEC, TICK_MIN).
- Computed in CNT_W+3 bits with no wrap; a negative intermediate clamps to TICK_MIN.

Step timer:
- T20_rst=1: counter<=0, no tick.
- Else if T20_en=1 and counter >= period-1: counter<=0, step_tick=1 for one cycle.
- Else if T20_en=1: counter increments.
- T20_en=0: counter holds.
- Using >= makes a period shrink mid-count fire on the next enabled cycle, with no overshoot or wrap.

Hit counter:
- Counts on the rising edge of Hit_ld, using a registered previous value. A Hit_ld held for many cycles counts once.
- Hit_clr has priority over an edge in the same cycle.
- Saturates at 255.

Level:
- When an accepted hit makes (hits since the last level-up) == HITS_PER_LVL and level < LVL_MAX: level+1, lvl_up pulses one cycle later, and the sub-counter clears.
- At LVL_MAX there is no increment and no pulse.
- Lvl_clr clears both the level and the sub-counter, with priority over a hit in the same cycle.
- Hit_clr alone does not clear the level.

Timeout FSM:
- T_IDLE -> T_RUN on T5_en=1 and T5_rst=0.
- T_RUN counts each cycle T5_en=1. Count hold when T5_en=0.
- At count == T5_TICKS-1: -> T_DONE, T5_done=1 from the next cycle.
- T_DONE holds T5_done=1 until T5_rst.
- T5_rst in any state: -> T_IDLE, count=0, T5_done=0 next cycle.
- Simultaneous T5_rst and terminal count: reset wins, T5_done stays 0.

Mid-operation reset:
- Rst at any time returns every output to its reset value asynchronously.

Latency:
- All outputs change one Clk after the causing input edge.

Optional Feature:
PONG_HIT_BCD_EN
- Defined: hit_count is two packed BCD digits (upper nibble = tens) and saturates at 0x99. Hit-to-level logic uses a separate binary sub-counter, so level behaviour is identical in both builds.
- Undefined: hit_count is plain binary and saturates at 255.

Decomposition:
- Package pong_pkg holds:
  - timeout FSM state encoding (T_IDLE, T_RUN, T_DONE);
  - LVL_W=3 and HIT_W=8;
  - default tick constants.
- One sub-module, pong_interval_timer: enable, clear, runtime period input, one-cycle terminal pulse. It is instantiated once for the step timer; the timeout FSM uses its own counter because T5_done is sticky.

Test Plan:
Use TICK_BASE=10, TICK_DEC=2, TICK_MIN=4, HITS_PER_LVL=3, LVL_MAX=3, T5_TICKS=20 unless a line says otherwise.
1. Release Rst, T20_en=1 for 35 cycles -> step_tick pulses at enabled cycles 10, 20, 30. T20_rst mid-count -> next pulse 10 cycles after release.
2. Hit_ld high for 5 cycles, repeated 3 times -> hit_count=3, level=1, one lvl_up pulse; step period now 8 cycles.
3. 12 separated hits -> level saturates at 3; period = max(10-6, 4) = 4; no lvl_up pulse after the third. Lvl_clr -> level=0, period back to 10.
4. T5_en=1 for 19 cycles -> T5_done=0; the 20th cycle -> T5_done=1, held with T5_en=0. T5_rst -> 0. T5_rst on the terminal cycle -> T5_done stays 0.
5. Hit_ld edge and Hit_clr in the same cycle -> hit_count=0. Rst asserted mid-count -> all outputs 0 immediately.
6. With PONG_HIT_BCD_EN, 12 hits -> hit_count=0x12; 120 hits -> 0x99. Without it, 300 hits -> 255.
